// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle: imem request/response, execute redirect and the decode-facing output.
// The master modport is the fetch unit side, the slave modport is the memory/pipeline environment.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at a time, holds it for decode,
// and handles execute redirects by withdrawing, draining or dropping in-flight fetches.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_HOLD,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_valid_q, req_valid_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);

    // Redirect always wins over a response or a decode handshake arriving in the same cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        case (state_q)
            S_HOLD: begin
                state_d = S_REQ;
                if (bus.redirect_valid) pc_d = redirect_tgt;
            end
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (bus.imem_req_ready) state_d = S_DRAIN;
                end else if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (bus.imem_rsp_valid) begin
                    out_pc_d    = pc_q;
                    out_instr_d = bus.imem_rsp_data;
                    pc_d        = pc_q + XLEN'(4);
                    state_d     = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (bus.out_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                // The stale response of the abandoned fetch is swallowed here.
                if (bus.redirect_valid) pc_d = redirect_tgt;
                else if (bus.imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_HOLD;
        endcase
        req_valid_d = (state_d == S_REQ);
        out_valid_d = (state_d == S_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HOLD;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_instr      = out_instr_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle vectors plus a scoreboard of delivered instructions.
// A second instance with RESET_PC at the top of the address space shares all inputs to cover PC wrap.
module tb_instr_fetch_unit;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] J    = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();
    instr_fetch_unit_if #(.XLEN(XLEN)) bus_w ();

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w.master)
    );

    assign bus_w.imem_req_ready = bus.imem_req_ready;
    assign bus_w.imem_rsp_valid = bus.imem_rsp_valid;
    assign bus_w.imem_rsp_data  = bus.imem_rsp_data;
    assign bus_w.redirect_valid = bus.redirect_valid;
    assign bus_w.redirect_pc    = bus.redirect_pc;
    assign bus_w.out_ready      = bus.out_ready;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] data;
        logic        ordy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        push;
        logic [31:0] push_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_row  = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] data,
                                input logic ordy, input logic redir, input logic [31:0] rpc,
                                input logic e_rqv, input logic [31:0] e_addr, input logic e_ov,
                                input logic [31:0] e_pc, input logic [31:0] e_ins,
                                input logic push, input logic [31:0] push_pc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.data = data; v.ordy = ordy; v.redir = redir; v.rpc = rpc;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ins = e_ins;
        v.push = push; v.push_pc = push_pc;
        return v;
    endfunction

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s (row %0d): got %h, expected %h", name, cur_row, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.imem_req_ready = v.rdy;
        bus.imem_rsp_valid = v.rv;
        bus.imem_rsp_data  = v.data;
        bus.out_ready      = v.ordy;
        bus.redirect_valid = v.redir;
        bus.redirect_pc    = v.rpc;
        if (v.push) sb.push_back('{pc: v.push_pc, instr: v.data});
    endtask

    task automatic checkOutput(input vec_t v);
        checkEq("req_valid", 32'(bus.imem_req_valid), 32'(v.e_rqv));
        if (v.e_rqv) checkEq("req_addr", bus.imem_req_addr, v.e_addr);
        checkEq("out_valid", 32'(bus.out_valid), 32'(v.e_ov));
        checkEq("out_pc", bus.out_pc, v.e_pc);
        checkEq("out_instr", bus.out_instr, v.e_ins);
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
    endtask

    // Every decode handshake not overridden by a redirect must deliver the oldest expected word.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL sb_unexpected: got pc %h, expected no delivery", bus.out_pc);
            end else begin
                sb_t e;
                e = sb.pop_front();
                checkEq("sb_pc", bus.out_pc, e.pc);
                checkEq("sb_instr", bus.out_instr, e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0);

        // Back-to-back fetch, decode stall, then a request held without acceptance.
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  1, 32'h0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h0), 1, 0, 0,  0, 0, 0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 1, 32'h0, mem_word(32'h0), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  1, 32'h4, 0, 32'h0, mem_word(32'h0), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h4), 1, 0, 0,  0, 0, 0, 32'h0, mem_word(32'h0), 1, 32'h4));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 1, 32'h4, mem_word(32'h4), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  1, 32'h8, 0, 32'h4, mem_word(32'h4), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h8), 1, 0, 0,  0, 0, 0, 32'h4, mem_word(32'h4), 1, 32'h8));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 1, J, 0, 0, 0,  0, 0, 1, 32'h8, mem_word(32'h8), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 1, 32'h8, mem_word(32'h8), 0, 0));
        vecs.push_back(mk(0, 1, J, 1, 0, 0,  1, 32'hC, 0, 32'h8, mem_word(32'h8), 0, 0));
        vecs.push_back(mk(0, 1, J, 1, 0, 0,  1, 32'hC, 0, 32'h8, mem_word(32'h8), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'hC, 0, 32'h8, mem_word(32'h8), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  0, 0, 0, 32'h8, mem_word(32'h8), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'hC), 1, 0, 0,  0, 0, 0, 32'h8, mem_word(32'h8), 1, 32'hC));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 1, 32'hC, mem_word(32'hC), 0, 0));
        // Redirect while waiting, with the stale response arriving three cycles later.
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'h10, 0, 32'hC, mem_word(32'hC), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 1, 32'h103,  0, 0, 0, 32'hC, mem_word(32'hC), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  0, 0, 0, 32'hC, mem_word(32'hC), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  0, 0, 0, 32'hC, mem_word(32'hC), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 0, 32'hC, mem_word(32'hC), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  1, 32'h100, 0, 32'hC, mem_word(32'hC), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h100), 1, 0, 0,  0, 0, 0, 32'hC, mem_word(32'hC), 1, 32'h100));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  0, 0, 1, 32'h100, mem_word(32'h100), 0, 0));
        // Redirect coincident with the response.
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'h104, 0, 32'h100, mem_word(32'h100), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 1, 32'h200,  0, 0, 0, 32'h100, mem_word(32'h100), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'h200, 0, 32'h100, mem_word(32'h100), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h200), 1, 0, 0,  0, 0, 0, 32'h100, mem_word(32'h100), 1, 32'h200));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  0, 0, 1, 32'h200, mem_word(32'h200), 0, 0));
        // Redirect in FULL beats out_ready; redirects in REQ with and without acceptance; in DRAIN.
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'h204, 0, 32'h200, mem_word(32'h200), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h204), 1, 0, 0,  0, 0, 0, 32'h200, mem_word(32'h200), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 1, 32'h300,  0, 0, 1, 32'h204, mem_word(32'h204), 0, 0));
        vecs.push_back(mk(0, 0, J, 1, 1, 32'h345,  1, 32'h300, 0, 32'h204, mem_word(32'h204), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 1, 32'h400,  1, 32'h344, 0, 32'h204, mem_word(32'h204), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 1, 32'h500,  0, 0, 0, 32'h204, mem_word(32'h204), 0, 0));
        vecs.push_back(mk(1, 1, J, 1, 0, 0,  0, 0, 0, 32'h204, mem_word(32'h204), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'h500, 0, 32'h204, mem_word(32'h204), 0, 0));
        vecs.push_back(mk(1, 1, mem_word(32'h500), 1, 0, 0,  0, 0, 0, 32'h204, mem_word(32'h204), 1, 32'h500));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  0, 0, 1, 32'h500, mem_word(32'h500), 0, 0));
        vecs.push_back(mk(1, 0, J, 1, 0, 0,  1, 32'h504, 0, 32'h500, mem_word(32'h500), 0, 0));

        applyStimulus(idle);
        repeat (3) @(posedge clk);
        #1;
        cur_row = -1;
        checkOutput(idle);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur_row = i;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i]);
            if (i == 1) begin
                checkEq("wrap_req_valid", 32'(bus_w.imem_req_valid), 32'd1);
                checkEq("wrap_req_addr", bus_w.imem_req_addr, 32'hFFFF_FFFC);
            end
            if (i == 3) begin
                checkEq("wrap_out_valid", 32'(bus_w.out_valid), 32'd1);
                checkEq("wrap_out_pc", bus_w.out_pc, 32'hFFFF_FFFC);
            end
            if (i == 4) begin
                checkEq("wrap_req_valid", 32'(bus_w.imem_req_valid), 32'd1);
                checkEq("wrap_req_addr", bus_w.imem_req_addr, 32'h0);
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in WAIT: outputs clear without any clock edge.
        cur_row = 100;
        applyStimulus(idle);
        #2;
        rst = 1'b0;
        #1;
        checkEq("async_out_valid", 32'(bus.out_valid), 32'd0);
        checkEq("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkEq("async_out_pc", bus.out_pc, 32'h0);
        checkEq("async_out_instr", bus.out_instr, 32'h0);
        checkEq("async_pc", bus.imem_req_addr, 32'h0);
        checkEq("async_wrap_out_pc", bus_w.out_pc, 32'h0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = J;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur_row = 101;
        runVec(mk(0, 1, J, 1, 0, 0,  0, 0, 0, 32'h0, 32'h0, 0, 0));
        runVec(mk(0, 1, J, 1, 0, 0,  1, 32'h0, 0, 32'h0, 32'h0, 0, 0));
        runVec(mk(1, 0, J, 1, 0, 0,  1, 32'h0, 0, 32'h0, 32'h0, 0, 0));
        runVec(mk(1, 1, mem_word(32'h0), 1, 0, 0,  0, 0, 0, 32'h0, 32'h0, 1, 32'h0));
        runVec(mk(0, 0, J, 1, 0, 0,  0, 0, 1, 32'h0, mem_word(32'h0), 0, 0));

        // Redirect during HOLD still moves to REQ, now at the redirect target.
        cur_row = 102;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        runVec(mk(0, 0, J, 0, 1, 32'h602,  0, 0, 0, 32'h0, 32'h0, 0, 0));
        runVec(mk(0, 0, J, 0, 0, 0,  1, 32'h600, 0, 32'h0, 32'h0, 0, 0));

        checkEq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
